// File: rtl/hsv_blob_centroid.sv
// hsv_blob_centroid: HSV window threshold to a registered mask, per-frame hit
// accumulation, and a serial restoring divide that publishes the blob centroid.
`default_nettype none

module hsv_blob_centroid #(
  parameter int X_W        = 11,
  parameter int Y_W        = 10,
  parameter int CNT_W      = 19,
  parameter int SUM_W      = 30,
  parameter int MIN_PIXELS = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       h,
  input  logic [7:0]       s,
  input  logic [7:0]       v,
  input  logic [X_W-1:0]   hcount,
  input  logic [Y_W-1:0]   vcount,
  input  logic             pixel_valid,
  input  logic             frame_end,
  input  logic [7:0]       h_min,
  input  logic [7:0]       h_max,
  input  logic [7:0]       s_min,
  input  logic [7:0]       v_min,
  output logic             mask,
  output logic             mask_valid,
  output logic [X_W-1:0]   centroid_x,
  output logic [Y_W-1:0]   centroid_y,
  output logic             centroid_valid,
  output logic             done,
  output logic             busy,
  output logic             dropped
);

  localparam int                BC_W     = $clog2(SUM_W);
  localparam logic [CNT_W-1:0]  MIN_CNT  = CNT_W'(MIN_PIXELS);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [BC_W-1:0]   LAST_BIT = BC_W'(SUM_W - 1);

  typedef enum logic [1:0] {
    S_ACCUM   = 2'd0,
    S_DIVX    = 2'd1,
    S_DIVY    = 2'd2,
    S_PUBLISH = 2'd3
  } state_t;

  state_t            state_q;
  logic              mask_q, mask_valid_q, done_q, dropped_q;
  logic [X_W-1:0]    centroid_x_q;
  logic [Y_W-1:0]    centroid_y_q;
  logic              centroid_valid_q;

  logic [SUM_W-1:0]  sum_x_q, sum_y_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SUM_W-1:0]  sum_x_d, sum_y_d;
  logic [CNT_W-1:0]  cnt_d;

  logic [SUM_W-1:0]  dvd_q;
  logic [SUM_W-1:0]  snap_y_q;
  logic [CNT_W-1:0]  div_q;
  logic [CNT_W-1:0]  rem_q;
  logic [X_W-2:0]    quo_q;
  logic [BC_W-1:0]   bit_q;
  logic [X_W-1:0]    cx_hold_q;
  logic [Y_W-1:0]    cy_hold_q;

  logic              in_h, hit;
  logic [CNT_W:0]    rem_sh;
  logic              rem_ge;
  logic [CNT_W-1:0]  rem_d;
  logic [X_W-1:0]    quo_d;

  // h_min > h_max selects a window that wraps through hue 0.
  assign in_h = (h_min <= h_max) ? ((h >= h_min) && (h <= h_max))
                                 : ((h >= h_min) || (h <= h_max));
  assign hit  = pixel_valid & in_h & (s >= s_min) & (v >= v_min);

  assign sum_x_d = sum_x_q + (hit ? SUM_W'(hcount) : '0);
  assign sum_y_d = sum_y_q + (hit ? SUM_W'(vcount) : '0);
  assign cnt_d   = (hit && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;

  // Remainder stays below the divisor, so the low CNT_W bits of the difference are exact.
  assign rem_sh = {rem_q, dvd_q[SUM_W-1]};
  assign rem_ge = (rem_sh >= {1'b0, div_q});
  assign rem_d  = rem_ge ? (rem_sh[CNT_W-1:0] - div_q) : rem_sh[CNT_W-1:0];
  assign quo_d  = {quo_q, rem_ge};

  always_ff @(posedge clock) begin
    if (reset || frame_end) begin
      sum_x_q <= '0;
      sum_y_q <= '0;
      cnt_q   <= '0;
    end else begin
      sum_x_q <= sum_x_d;
      sum_y_q <= sum_y_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= S_ACCUM;
      mask_q           <= 1'b0;
      mask_valid_q     <= 1'b0;
      done_q           <= 1'b0;
      dropped_q        <= 1'b0;
      centroid_x_q     <= '0;
      centroid_y_q     <= '0;
      centroid_valid_q <= 1'b0;
      dvd_q            <= '0;
      snap_y_q         <= '0;
      div_q            <= '0;
      rem_q            <= '0;
      quo_q            <= '0;
      bit_q            <= '0;
      cx_hold_q        <= '0;
      cy_hold_q        <= '0;
    end else begin
      mask_q       <= hit;
      mask_valid_q <= pixel_valid;
      done_q       <= 1'b0;
      dropped_q    <= frame_end && (state_q != S_ACCUM);

      case (state_q)
        S_ACCUM: begin
          if (frame_end) begin
            dvd_q    <= sum_x_d;
            snap_y_q <= sum_y_d;
            div_q    <= cnt_d;
            rem_q    <= '0;
            quo_q    <= '0;
            bit_q    <= '0;
            state_q  <= (cnt_d < MIN_CNT) ? S_PUBLISH : S_DIVX;
          end
        end

        S_DIVX: begin
          rem_q <= rem_d;
          quo_q <= quo_d[X_W-2:0];
          dvd_q <= {dvd_q[SUM_W-2:0], 1'b0};
          bit_q <= bit_q + BC_W'(1);
          if (bit_q == LAST_BIT) begin
            cx_hold_q <= quo_d;
            dvd_q     <= snap_y_q;
            rem_q     <= '0;
            quo_q     <= '0;
            bit_q     <= '0;
            state_q   <= S_DIVY;
          end
        end

        S_DIVY: begin
          rem_q <= rem_d;
          quo_q <= quo_d[X_W-2:0];
          dvd_q <= {dvd_q[SUM_W-2:0], 1'b0};
          bit_q <= bit_q + BC_W'(1);
          if (bit_q == LAST_BIT) begin
            cy_hold_q <= quo_d[Y_W-1:0];
            state_q   <= S_PUBLISH;
          end
        end

        S_PUBLISH: begin
          done_q <= 1'b1;
          if (div_q >= MIN_CNT) begin
            centroid_x_q     <= cx_hold_q;
            centroid_y_q     <= cy_hold_q;
            centroid_valid_q <= 1'b1;
          end else begin
            centroid_valid_q <= 1'b0;
          end
          state_q <= S_ACCUM;
        end

        default: state_q <= S_ACCUM;
      endcase
    end
  end

  assign mask           = mask_q;
  assign mask_valid     = mask_valid_q;
  assign centroid_x     = centroid_x_q;
  assign centroid_y     = centroid_y_q;
  assign centroid_valid = centroid_valid_q;
  assign done           = done_q;
  assign dropped        = dropped_q;
  assign busy           = (state_q != S_ACCUM);

endmodule

`default_nettype wire

// File: tb/tb_hsv_blob_centroid.sv
// Directed bench for hsv_blob_centroid: thresholds, centroid math, latency,
// drop handling and mid-division reset.
`default_nettype none

module tb_hsv_blob_centroid;
  localparam int X_W = 11;
  localparam int Y_W = 10;

  logic           clock = 1'b0;
  logic           reset;
  logic [7:0]     h, s, v, h_min, h_max, s_min, v_min;
  logic [X_W-1:0] hcount;
  logic [Y_W-1:0] vcount;
  logic           pixel_valid, frame_end;
  logic           mask, mask_valid, centroid_valid, done, busy, dropped;
  logic [X_W-1:0] centroid_x;
  logic [Y_W-1:0] centroid_y;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;
  int n_done;

  hsv_blob_centroid dut (
    .clock(clock), .reset(reset), .h(h), .s(s), .v(v),
    .hcount(hcount), .vcount(vcount), .pixel_valid(pixel_valid), .frame_end(frame_end),
    .h_min(h_min), .h_max(h_max), .s_min(s_min), .v_min(v_min),
    .mask(mask), .mask_valid(mask_valid), .centroid_x(centroid_x), .centroid_y(centroid_y),
    .centroid_valid(centroid_valid), .done(done), .busy(busy), .dropped(dropped)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int x, input int y, input logic [7:0] hh, input logic [7:0] ss,
                       input logic [7:0] vv);
    hcount      = x[X_W-1:0];
    vcount      = y[Y_W-1:0];
    h           = hh;
    s           = ss;
    v           = vv;
    pixel_valid = 1'b1;
  endtask

  // Drive one pixel at a negedge and advance to the next negedge.
  task automatic px(input int x, input int y, input logic [7:0] hh, input logic [7:0] ss,
                    input logic [7:0] vv);
    drive(x, y, hh, ss, vv);
    @(negedge clock);
  endtask

  task automatic square();
    for (int yy = 50; yy <= 59; yy++)
      for (int xx = 100; xx <= 109; xx++)
        px(xx, yy, 8'd30, 8'd200, 8'd200);
  endtask

  // Pulse frame_end and return at the negedge where done is seen; lat counts cycles.
  task automatic fe_wait(output int l);
    pixel_valid = 1'b0;
    frame_end   = 1'b1;
    @(negedge clock);
    frame_end = 1'b0;
    l = 1;
    while (done !== 1'b1 && l < 200) begin
      @(negedge clock);
      l++;
    end
  endtask

  initial begin
    reset = 1'b1; pixel_valid = 1'b0; frame_end = 1'b0;
    h = 8'd0; s = 8'd0; v = 8'd0; hcount = '0; vcount = '0;
    h_min = 8'd30; h_max = 8'd40; s_min = 8'd100; v_min = 8'd100;
    repeat (3) @(negedge clock);
    chk("rst_mask", {31'd0, mask}, 0);
    chk("rst_mask_valid", {31'd0, mask_valid}, 0);
    chk("rst_cx", 32'(centroid_x), 0);
    chk("rst_cy", 32'(centroid_y), 0);
    chk("rst_cvalid", {31'd0, centroid_valid}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_dropped", {31'd0, dropped}, 0);
    reset = 1'b0;
    @(negedge clock);

    // Black frame: skip path
    for (int i = 0; i < 5; i++) px(i, 0, 8'd0, 8'd0, 8'd0);
    chk("t1_mask", {31'd0, mask}, 0);
    chk("t1_mask_valid", {31'd0, mask_valid}, 1);
    fe_wait(lat);
    chk("t1_latency", lat, 2);
    chk("t1_cvalid", {31'd0, centroid_valid}, 0);
    chk("t1_cx", 32'(centroid_x), 0);
    chk("t1_cy", 32'(centroid_y), 0);
    chk("t1_busy", {31'd0, busy}, 0);

    // 10x10 square centred at (104.5, 54.5)
    px(0, 0, 8'd0, 8'd0, 8'd0);
    chk("t2_bg_mask", {31'd0, mask}, 0);
    square();
    chk("t2_sq_mask", {31'd0, mask}, 1);
    fe_wait(lat);
    chk("t2_latency", lat, 62);
    chk("t2_cx", 32'(centroid_x), 104);
    chk("t2_cy", 32'(centroid_y), 54);
    chk("t2_cvalid", {31'd0, centroid_valid}, 1);

    // Wrap-around hue window
    h_min = 8'd250; h_max = 8'd10;
    px(1, 1, 8'd5, 8'd200, 8'd200);
    chk("t3_h5", {31'd0, mask}, 1);
    px(2, 1, 8'd252, 8'd200, 8'd200);
    chk("t3_h252", {31'd0, mask}, 1);
    px(3, 1, 8'd128, 8'd200, 8'd200);
    chk("t3_h128", {31'd0, mask}, 0);
    chk("t3_h128_valid", {31'd0, mask_valid}, 1);
    px(4, 1, 8'd10, 8'd200, 8'd200);
    chk("t3_h10", {31'd0, mask}, 1);
    px(5, 1, 8'd11, 8'd200, 8'd200);
    chk("t3_h11", {31'd0, mask}, 0);
    pixel_valid = 1'b0;
    @(negedge clock);
    chk("t3_idle_valid", {31'd0, mask_valid}, 0);
    fe_wait(lat);
    chk("t3_latency", lat, 2);
    chk("t3_cvalid", {31'd0, centroid_valid}, 0);
    chk("t3_cx_hold", 32'(centroid_x), 104);

    // 63 hits: below threshold, with window-edge probes
    h_min = 8'd30; h_max = 8'd40;
    px(999, 999, 8'd29, 8'd200, 8'd200);
    chk("t4_h29", {31'd0, mask}, 0);
    px(999, 999, 8'd41, 8'd200, 8'd200);
    chk("t4_h41", {31'd0, mask}, 0);
    px(999, 999, 8'd35, 8'd99, 8'd200);
    chk("t4_s99", {31'd0, mask}, 0);
    px(999, 999, 8'd35, 8'd200, 8'd99);
    chk("t4_v99", {31'd0, mask}, 0);
    px(10, 10, 8'd30, 8'd100, 8'd100);
    chk("t4_lo_edge", {31'd0, mask}, 1);
    px(10, 10, 8'd40, 8'd100, 8'd100);
    chk("t4_hi_edge", {31'd0, mask}, 1);
    for (int i = 0; i < 61; i++) px(10, 10, 8'd35, 8'd200, 8'd200);
    fe_wait(lat);
    chk("t4_63_latency", lat, 2);
    chk("t4_63_cvalid", {31'd0, centroid_valid}, 0);
    chk("t4_63_cx", 32'(centroid_x), 104);
    chk("t4_63_cy", 32'(centroid_y), 54);

    for (int i = 0; i < 64; i++) px(200, 100, 8'd35, 8'd200, 8'd200);
    fe_wait(lat);
    chk("t4_64_latency", lat, 62);
    chk("t4_64_cvalid", {31'd0, centroid_valid}, 1);
    chk("t4_64_cx", 32'(centroid_x), 200);
    chk("t4_64_cy", 32'(centroid_y), 100);

    // frame_end during DIVX
    square();
    pixel_valid = 1'b0;
    frame_end   = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      @(negedge clock);
      frame_end = 1'b0;
      drive(500, 400, 8'd35, 8'd200, 8'd200);
    end
    @(negedge clock);
    pixel_valid = 1'b0;
    frame_end   = 1'b1;
    chk("t5_busy", {31'd0, busy}, 1);
    @(negedge clock);
    frame_end = 1'b0;
    chk("t5_dropped", {31'd0, dropped}, 1);
    lat = 21;
    while (done !== 1'b1 && lat < 200) begin
      drive(300, 200, 8'd35, 8'd200, 8'd200);
      @(negedge clock);
      lat++;
    end
    pixel_valid = 1'b0;
    chk("t5_latency", lat, 62);
    chk("t5_cx", 32'(centroid_x), 104);
    chk("t5_cy", 32'(centroid_y), 54);
    chk("t5_cvalid", {31'd0, centroid_valid}, 1);
    chk("t5_dropped_clear", {31'd0, dropped}, 0);
    for (int i = 0; i < 23; i++) px(300, 200, 8'd35, 8'd200, 8'd200);
    fe_wait(lat);
    chk("t5_next_latency", lat, 62);
    chk("t5_next_cx", 32'(centroid_x), 300);
    chk("t5_next_cy", 32'(centroid_y), 200);
    chk("t5_next_cvalid", {31'd0, centroid_valid}, 1);

    // Reset during DIVY
    square();
    pixel_valid = 1'b0;
    frame_end   = 1'b1;
    @(negedge clock);
    frame_end = 1'b0;
    repeat (39) @(negedge clock);
    chk("t6_busy_before", {31'd0, busy}, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_done", {31'd0, done}, 0);
    chk("t6_cx", 32'(centroid_x), 0);
    chk("t6_cy", 32'(centroid_y), 0);
    chk("t6_cvalid", {31'd0, centroid_valid}, 0);
    chk("t6_mask_valid", {31'd0, mask_valid}, 0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done === 1'b1) n_done++;
    end
    chk("t6_no_done", n_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
